seven_seg_scanner: RTL

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner_pkg.sv | 33 +++
 rtl/seven_seg_scanner_decoder.sv | 32 +++
 rtl/seven_seg_scanner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_pkg.sv
`default_nettype none
// ============================================================================
// seven_seg_scanner_pkg : display codes, segment patterns and digit count
// Revision 1.0
// ============================================================================
package seven_seg_scanner_pkg;

    localparam int         NUM_DIGITS = 4;

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // A digit that is zero or blank lets the next lower zero be blanked too
    function automatic logic is_zero_or_blank(input logic [3:0] code);
        return (code == 4'h0) || (code >= CODE_BLANK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scanner_decoder.sv
`default_nettype none
// ============================================================================
// seg7_decoder : combinational display-code to active-low segment decoder
// Revision 1.0
// ============================================================================
module seg7_decoder
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'h0:       seg_o = SEG_0;
            4'h1:       seg_o = SEG_1;
            4'h2:       seg_o = SEG_2;
            4'h3:       seg_o = SEG_3;
            4'h4:       seg_o = SEG_4;
            4'h5:       seg_o = SEG_5;
            4'h6:       seg_o = SEG_6;
            4'h7:       seg_o = SEG_7;
            4'h8:       seg_o = SEG_8;
            4'h9:       seg_o = SEG_9;
            CODE_MINUS: seg_o = SEG_MINUS;
            default:    seg_o = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// seven_seg_scanner : 4-digit multiplexed 7-segment driver, frame-synchronous
//                     shadow update and leading-zero blanking
// Revision 1.0
// ============================================================================
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit LZB         = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      shadow_code_q, shadow_code_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic             pending_q, pending_d;
    logic [15:0]      active_code_q, active_code_d;
    logic [3:0]       active_dp_q, active_dp_d;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic             frame_done_q;

    logic             tick;
    logic             commit;
    logic [3:0]       lz_blank;
    logic             higher_clear;
    logic [3:0]       sel_code;
    logic [3:0]       disp_code;
    logic             dp_on;
    logic [6:0]       seg_dec;

    assign tick   = (cnt_q == CNT_LAST);
    assign commit = tick && (idx_q == 2'd3);

    always_comb begin
        cnt_d         = tick ? '0 : cnt_q + 1'b1;
        idx_d         = tick ? idx_q + 2'd1 : idx_q;
        shadow_code_d = shadow_code_q;
        shadow_dp_d   = shadow_dp_q;
        pending_d     = pending_q;
        active_code_d = active_code_q;
        active_dp_d   = active_dp_q;
        // Commit reads the old shadow; a coinciding load stays pending
        if (commit && pending_q) begin
            active_code_d = shadow_code_q;
            active_dp_d   = shadow_dp_q;
            pending_d     = 1'b0;
        end
        if (load) begin
            shadow_code_d = data_in;
            shadow_dp_d   = dp_in;
            pending_d     = 1'b1;
        end
    end

    always_comb begin
        lz_blank     = '0;
        higher_clear = LZB;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (higher_clear && (active_code_q[k*4 +: 4] == 4'h0))
                lz_blank[k] = 1'b1;
            higher_clear = higher_clear && is_zero_or_blank(active_code_q[k*4 +: 4]);
        end
    end

    assign sel_code  = active_code_q[{idx_q, 2'b00} +: 4];
    assign disp_code = lz_blank[idx_q] ? CODE_BLANK : sel_code;
    assign dp_on     = active_dp_q[idx_q] & ~lz_blank[idx_q];

    seg7_decoder u_dec (
        .code_i (disp_code),
        .seg_o  (seg_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            shadow_code_q <= {4{CODE_BLANK}};
            shadow_dp_q   <= 4'b0000;
            pending_q     <= 1'b0;
            active_code_q <= {4{CODE_BLANK}};
            active_dp_q   <= 4'b0000;
            an_q          <= 4'b1111;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_code_q <= shadow_code_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            active_code_q <= active_code_d;
            active_dp_q   <= active_dp_d;
            an_q          <= ~(4'b0001 << idx_q);
            seg_q         <= seg_dec;
            dp_q          <= ~dp_on;
            frame_done_q  <= commit;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
